// File: rtl/data_mem_bridge.sv
// Memory-stage bus bridge: turns M-stage loads/stores into a req/ack bus
// transaction, stalls the pipeline while waiting, and owns the M/W register.
module data_mem_bridge #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  WA3M,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        StallMem,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [3:0]  WA3W,
  output logic        err_misaligned,
  output logic        err_timeout
);

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 4;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [DW-1:0]   bus_addr_q, bus_addr_d;
  logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
  logic            reg_write_w_q, reg_write_w_d;
  logic            mem_to_reg_w_q, mem_to_reg_w_d;
  logic [DW-1:0]   read_data_w_q, read_data_w_d;
  logic [DW-1:0]   alu_out_w_q, alu_out_w_d;
  logic [RW-1:0]   wa3_w_q, wa3_w_d;
  logic            err_mis_q, err_mis_d;
  logic            err_to_q, err_to_d;
  logic            stall_c;

  logic acc_c, aligned_c, expire_c;
  assign acc_c     = MemtoRegM | MemWriteM;
  assign aligned_c = (ALUResultM[1:0] == 2'b00);
  assign expire_c  = (cnt_q == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (acc_c && aligned_c) state_d = ST_WAIT;
      ST_WAIT: if (bus_ack || expire_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; a stalled cycle loads a bubble into W
  always_comb begin
    stall_c        = 1'b0;
    cnt_d          = cnt_q;
    bus_req_d      = bus_req_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    reg_write_w_d  = reg_write_w_q;
    mem_to_reg_w_d = mem_to_reg_w_q;
    read_data_w_d  = read_data_w_q;
    alu_out_w_d    = alu_out_w_q;
    wa3_w_d        = wa3_w_q;
    err_mis_d      = err_mis_q;
    err_to_d       = err_to_q;
    case (state_q)
      ST_IDLE: begin
        if (acc_c && aligned_c) begin
          stall_c        = 1'b1;
          bus_req_d      = 1'b1;
          bus_we_d       = MemWriteM;
          bus_addr_d     = ALUResultM;
          bus_wdata_d    = WriteDataM;
          cnt_d          = '0;
          reg_write_w_d  = 1'b0;
          mem_to_reg_w_d = 1'b0;
        end else begin
          // Misaligned accesses retire without writing the register file
          reg_write_w_d  = RegWriteM & ~acc_c;
          mem_to_reg_w_d = MemtoRegM;
          read_data_w_d  = '0;
          alu_out_w_d    = ALUResultM;
          wa3_w_d        = WA3M;
          if (acc_c) err_mis_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus_ack) begin
          bus_req_d      = 1'b0;
          reg_write_w_d  = RegWriteM;
          mem_to_reg_w_d = MemtoRegM;
          read_data_w_d  = MemWriteM ? '0 : bus_rdata;
          alu_out_w_d    = ALUResultM;
          wa3_w_d        = WA3M;
        end else if (expire_c) begin
          bus_req_d      = 1'b0;
          reg_write_w_d  = 1'b0;
          mem_to_reg_w_d = MemtoRegM;
          read_data_w_d  = '0;
          alu_out_w_d    = ALUResultM;
          wa3_w_d        = WA3M;
          err_to_d       = 1'b1;
        end else begin
          stall_c        = 1'b1;
          cnt_d          = cnt_q + CW'(1);
          reg_write_w_d  = 1'b0;
          mem_to_reg_w_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Bus, M/W pipeline and error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      reg_write_w_q  <= 1'b0;
      mem_to_reg_w_q <= 1'b0;
      read_data_w_q  <= '0;
      alu_out_w_q    <= '0;
      wa3_w_q        <= '0;
      err_mis_q      <= 1'b0;
      err_to_q       <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      bus_req_q      <= bus_req_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
      reg_write_w_q  <= reg_write_w_d;
      mem_to_reg_w_q <= mem_to_reg_w_d;
      read_data_w_q  <= read_data_w_d;
      alu_out_w_q    <= alu_out_w_d;
      wa3_w_q        <= wa3_w_d;
      err_mis_q      <= err_mis_d;
      err_to_q       <= err_to_d;
    end
  end

  assign StallMem       = stall_c;
  assign bus_req        = bus_req_q;
  assign bus_we         = bus_we_q;
  assign bus_addr       = bus_addr_q;
  assign bus_wdata      = bus_wdata_q;
  assign RegWriteW      = reg_write_w_q;
  assign MemtoRegW      = mem_to_reg_w_q;
  assign ReadDataW      = read_data_w_q;
  assign ALUOutW        = alu_out_w_q;
  assign WA3W           = wa3_w_q;
  assign err_misaligned = err_mis_q;
  assign err_timeout    = err_to_q;

endmodule
